// File: rtl/mux_switch_sequencer.sv
// Sequences a design-mux switch: hold all design resets, clock the new select into the
// mux control flops with a few conf-clock pulses, settle, then release the chosen design.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | ready for a request; outputs hold last committed values
// ASSERT | all design resets forced high, old select still driven
// PULSE  | new select/enables driven, conf clock toggles low-first
// SETTLE | conf clock low, everything held while the mux settles
// DONE   | one-cycle done pulse, selected design released from reset
module mux_switch_sequencer #(
   parameter int unsigned RST_CYCLES    = 4,
   parameter int unsigned CONF_PULSES   = 3,
   parameter int unsigned SETTLE_CYCLES = 8
) (
   input  logic       wb_clk_i,
   input  logic       rst_n,
   input  logic       i_req_valid,
   output logic       o_req_ready,
   input  logic [3:0] i_req_sel,
   input  logic       i_req_sys_reset_en,
   input  logic       i_req_auto_reset_en,
   output logic       o_mux_conf_clk,
   output logic [3:0] o_mux_sel,
   output logic       o_mux_sys_reset_enb,
   output logic       o_mux_auto_reset_enb,
   output logic [7:0] o_design_reset,
   output logic       o_busy,
   output logic       o_done,
   output logic [3:0] o_cur_sel
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ASSERT = 3'd1,
      ST_PULSE  = 3'd2,
      ST_SETTLE = 3'd3,
      ST_DONE   = 3'd4
   } state_e;

   // Terminal counts: each state reloads its down-counter on entry and exits at zero.
   localparam logic [7:0] ASSERT_TC = 8'(RST_CYCLES - 1);
   localparam logic [7:0] PULSE_TC  = 8'(2 * CONF_PULSES - 1);
   localparam logic [7:0] SETTLE_TC = 8'(SETTLE_CYCLES - 1);

   state_e     state_q;
   logic [7:0] cnt_q;
   logic [3:0] req_sel_q;
   logic       req_sys_en_q;
   logic       req_auto_en_q;
   logic       conf_clk_q;
   logic [3:0] mux_sel_q;
   logic       sys_enb_q;
   logic       auto_enb_q;
   logic [7:0] design_reset_q;
   logic       done_q;
   logic [3:0] cur_sel_q;
   logic [7:0] release_mask;

   // Designs 8..15 have no reset line, so selecting them keeps every design in reset.
   always_comb begin
      release_mask = 8'hFF;
      if (!req_sel_q[3]) begin
         release_mask = ~(8'h01 << req_sel_q[2:0]);
      end
   end

   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         cnt_q          <= 8'd0;
         req_sel_q      <= 4'hF;
         req_sys_en_q   <= 1'b0;
         req_auto_en_q  <= 1'b1;
         conf_clk_q     <= 1'b0;
         mux_sel_q      <= 4'hF;
         sys_enb_q      <= 1'b1;
         auto_enb_q     <= 1'b0;
         design_reset_q <= 8'hFF;
         done_q         <= 1'b0;
         cur_sel_q      <= 4'hF;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (i_req_valid) begin
                  req_sel_q      <= i_req_sel;
                  req_sys_en_q   <= i_req_sys_reset_en;
                  req_auto_en_q  <= i_req_auto_reset_en;
                  design_reset_q <= 8'hFF;
                  cnt_q          <= ASSERT_TC;
                  state_q        <= ST_ASSERT;
               end
            end
            ST_ASSERT: begin
               if (cnt_q == 8'd0) begin
                  // New select lands while conf clock is low, ahead of the first rising edge.
                  mux_sel_q  <= req_sel_q;
                  sys_enb_q  <= ~req_sys_en_q;
                  auto_enb_q <= ~req_auto_en_q;
                  conf_clk_q <= 1'b0;
                  cnt_q      <= PULSE_TC;
                  state_q    <= ST_PULSE;
               end else begin
                  cnt_q <= cnt_q - 8'd1;
               end
            end
            ST_PULSE: begin
               if (cnt_q == 8'd0) begin
                  conf_clk_q <= 1'b0;
                  cnt_q      <= SETTLE_TC;
                  state_q    <= ST_SETTLE;
               end else begin
                  conf_clk_q <= ~conf_clk_q;
                  cnt_q      <= cnt_q - 8'd1;
               end
            end
            ST_SETTLE: begin
               if (cnt_q == 8'd0) begin
                  done_q         <= 1'b1;
                  cur_sel_q      <= req_sel_q;
                  design_reset_q <= release_mask;
                  state_q        <= ST_DONE;
               end else begin
                  cnt_q <= cnt_q - 8'd1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               conf_clk_q <= 1'b0;
               state_q    <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_req_ready          = (state_q == ST_IDLE);
   assign o_busy               = (state_q != ST_IDLE);
   assign o_mux_conf_clk       = conf_clk_q;
   assign o_mux_sel            = mux_sel_q;
   assign o_mux_sys_reset_enb  = sys_enb_q;
   assign o_mux_auto_reset_enb = auto_enb_q;
   assign o_design_reset       = design_reset_q;
   assign o_done               = done_q;
   assign o_cur_sel            = cur_sel_q;

endmodule

// File: tb/tb_mux_switch_sequencer.sv
// Bench for mux_switch_sequencer: a default instance and a minimum-parameter instance,
// both checked every cycle against a timeline model of the switch sequence.
module tb_mux_switch_sequencer;

   localparam int RA = 4, PA = 3, SA = 8;
   localparam int RB = 1, PB = 2, SB = 1;

   typedef struct packed {
      logic       ready;
      logic       busy;
      logic       done;
      logic       conf;
      logic [3:0] mux_sel;
      logic       sys_enb;
      logic       auto_enb;
      logic [7:0] dres;
      logic [3:0] cur_sel;
   } outs_t;

   typedef struct packed {
      logic [3:0] sel;
      logic       sys;
      logic       aut;
   } req_t;

   localparam outs_t RST_OUTS = {1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 1'b1, 1'b0, 8'hFF, 4'hF};

   logic       clk = 1'b0;
   logic       rst_n;
   logic       valid_a, valid_b;
   logic [3:0] req_sel;
   logic       req_sys, req_auto;

   logic       ready_a, busy_a, done_a, conf_a, sysb_a, autob_a;
   logic [3:0] sel_a, cur_a;
   logic [7:0] dres_a;
   logic       ready_b, busy_b, done_b, conf_b, sysb_b, autob_b;
   logic [3:0] sel_b, cur_b;
   logic [7:0] dres_b;

   outs_t obs_a, obs_b, last_a, last_b;
   int    n_vec = 0;
   int    n_err = 0;

   always #5 clk = ~clk;

   mux_switch_sequencer dut_a (
      .wb_clk_i(clk), .rst_n(rst_n),
      .i_req_valid(valid_a), .o_req_ready(ready_a), .i_req_sel(req_sel),
      .i_req_sys_reset_en(req_sys), .i_req_auto_reset_en(req_auto),
      .o_mux_conf_clk(conf_a), .o_mux_sel(sel_a),
      .o_mux_sys_reset_enb(sysb_a), .o_mux_auto_reset_enb(autob_a),
      .o_design_reset(dres_a), .o_busy(busy_a), .o_done(done_a), .o_cur_sel(cur_a)
   );

   mux_switch_sequencer #(.RST_CYCLES(RB), .CONF_PULSES(PB), .SETTLE_CYCLES(SB)) dut_b (
      .wb_clk_i(clk), .rst_n(rst_n),
      .i_req_valid(valid_b), .o_req_ready(ready_b), .i_req_sel(req_sel),
      .i_req_sys_reset_en(req_sys), .i_req_auto_reset_en(req_auto),
      .o_mux_conf_clk(conf_b), .o_mux_sel(sel_b),
      .o_mux_sys_reset_enb(sysb_b), .o_mux_auto_reset_enb(autob_b),
      .o_design_reset(dres_b), .o_busy(busy_b), .o_done(done_b), .o_cur_sel(cur_b)
   );

   assign obs_a = {ready_a, busy_a, done_a, conf_a, sel_a, sysb_a, autob_a, dres_a, cur_a};
   assign obs_b = {ready_b, busy_b, done_b, conf_b, sel_b, sysb_b, autob_b, dres_b, cur_b};

   // Expected outputs in cycle T+k of a sequence accepted at edge T (k >= 1).
   function automatic outs_t model(int k, int r, int p, int s, req_t q, outs_t prev);
      outs_t      e;
      int         total;
      logic [7:0] one;
      one   = 8'h01;
      total = r + 2 * p + s + 1;
      e     = prev;
      e.ready = (k > total);
      e.busy  = !(k > total);
      e.done  = (k == total);
      e.conf  = (k > r) && (k <= r + 2 * p) && (((k - r) % 2) == 0);
      if (k > r) begin
         e.mux_sel  = q.sel;
         e.sys_enb  = !q.sys;
         e.auto_enb = !q.aut;
      end
      if (k < total) e.dres = 8'hFF;
      else if (q.sel < 4'd8) e.dres = ~(one << q.sel[2:0]);
      else e.dres = 8'hFF;
      if (k >= total) e.cur_sel = q.sel;
      return e;
   endfunction

   task automatic drive_req(input req_t q, input logic va, input logic vb);
      req_sel  = q.sel;
      req_sys  = q.sys;
      req_auto = q.aut;
      valid_a  = va;
      valid_b  = vb;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      drive_req('0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if (obs_a !== RST_OUTS) begin n_err++; $display("FAIL reset_a got %h want %h", obs_a, RST_OUTS); end
      n_vec++;
      if (obs_b !== RST_OUTS) begin n_err++; $display("FAIL reset_b got %h want %h", obs_b, RST_OUTS); end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      n_vec++;
      if (obs_a !== RST_OUTS) begin n_err++; $display("FAIL first_clk_a got %h want %h", obs_a, RST_OUTS); end
      n_vec++;
      if (obs_b !== RST_OUTS) begin n_err++; $display("FAIL first_clk_b got %h want %h", obs_b, RST_OUTS); end
      last_a = RST_OUTS;
      last_b = RST_OUTS;
      @(negedge clk);
   endtask

   // Directed sel=2, sel=12, a repeat of the committed select, then random requests.
   task automatic test_sequences();
      req_t  q;
      outs_t e;
      int    edges_a, edges_b, dones_a, dones_b;
      logic  pc_a, pc_b;
      for (int i = 0; i < 9; i++) begin
         q.sel = 4'($urandom_range(15, 0));
         q.sys = 1'($urandom_range(1, 0));
         q.aut = 1'($urandom_range(1, 0));
         if (i == 0) q = {4'd2, 1'b1, 1'b1};
         if (i == 1) q.sel = 4'd12;
         if (i == 3) q.sel = last_a.cur_sel;
         edges_a = 0; edges_b = 0; dones_a = 0; dones_b = 0;
         pc_a = 1'b0; pc_b = 1'b0;
         drive_req(q, 1'b1, 1'b1);
         for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            if (k == 1) begin valid_a = 1'b0; valid_b = 1'b0; end
            e = model(k, RA, PA, SA, q, last_a);
            n_vec++;
            if (obs_a !== e) begin n_err++; $display("FAIL seq_a i=%0d k=%0d got %h want %h", i, k, obs_a, e); end
            e = model(k, RB, PB, SB, q, last_b);
            n_vec++;
            if (obs_b !== e) begin n_err++; $display("FAIL seq_b i=%0d k=%0d got %h want %h", i, k, obs_b, e); end
            if (conf_a && !pc_a) edges_a++;
            if (conf_b && !pc_b) edges_b++;
            if (done_a) dones_a++;
            if (done_b) dones_b++;
            pc_a = conf_a;
            pc_b = conf_b;
         end
         n_vec++;
         if (edges_a != PA) begin n_err++; $display("FAIL conf_edges_a got %0d want %0d", edges_a, PA); end
         n_vec++;
         if (edges_b != PB) begin n_err++; $display("FAIL conf_edges_b got %0d want %0d", edges_b, PB); end
         n_vec++;
         if (dones_a != 1 || dones_b != 1) begin
            n_err++; $display("FAIL done_count got a=%0d b=%0d want 1", dones_a, dones_b);
         end
         last_a = model(21, RA, PA, SA, q, last_a);
         last_b = model(21, RB, PB, SB, q, last_b);
      end
   endtask

   // Request raised mid-sequence must wait for ready, then run with sel=0.
   task automatic test_back_to_back();
      req_t  q1, q2;
      outs_t e;
      q1 = {4'($urandom_range(7, 1)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0))};
      q2 = {4'd0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0))};
      drive_req(q1, 1'b1, 1'b1);
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         e = model(k, RA, PA, SA, q1, last_a);
         n_vec++;
         if (obs_a !== e) begin n_err++; $display("FAIL b2b_first_a k=%0d got %h want %h", k, obs_a, e); end
         e = model(k, RB, PB, SB, q1, last_b);
         n_vec++;
         if (obs_b !== e) begin n_err++; $display("FAIL b2b_first_b k=%0d got %h want %h", k, obs_b, e); end
         if (k == 1) begin valid_a = 1'b0; valid_b = 1'b0; end
         if (k == 3) drive_req(q2, 1'b1, 1'b0);
      end
      last_a = model(20, RA, PA, SA, q1, last_a);
      last_b = model(20, RB, PB, SB, q1, last_b);
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) valid_a = 1'b0;
         e = model(k, RA, PA, SA, q2, last_a);
         n_vec++;
         if (obs_a !== e) begin n_err++; $display("FAIL b2b_second_a k=%0d got %h want %h", k, obs_a, e); end
         n_vec++;
         if (obs_b !== last_b) begin n_err++; $display("FAIL b2b_idle_b k=%0d got %h want %h", k, obs_b, last_b); end
      end
      n_vec++;
      if (dres_a !== 8'hFE) begin n_err++; $display("FAIL b2b_final_dres got %h want fe", dres_a); end
      last_a = model(20, RA, PA, SA, q2, last_a);
   endtask

   // Request fields changed after accept must not leak into the sequence.
   task automatic test_sample_once();
      req_t  q;
      outs_t e;
      q = {4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0))};
      drive_req(q, 1'b1, 1'b1);
      for (int k = 1; k <= 21; k++) begin
         @(negedge clk);
         if (k == 1) begin valid_a = 1'b0; valid_b = 1'b0; end
         if (k == 2) begin req_sel = q.sel ^ 4'h5; req_sys = !q.sys; req_auto = !q.aut; end
         e = model(k, RA, PA, SA, q, last_a);
         n_vec++;
         if (obs_a !== e) begin n_err++; $display("FAIL sample_a k=%0d got %h want %h", k, obs_a, e); end
         e = model(k, RB, PB, SB, q, last_b);
         n_vec++;
         if (obs_b !== e) begin n_err++; $display("FAIL sample_b k=%0d got %h want %h", k, obs_b, e); end
      end
      last_a = model(21, RA, PA, SA, q, last_a);
      last_b = model(21, RB, PB, SB, q, last_b);
   endtask

   // Reset pulled mid-PULSE forces reset values at once and stops the sequence.
   task automatic test_abort();
      req_t  q;
      outs_t e;
      q = {4'($urandom_range(7, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0))};
      drive_req(q, 1'b1, 1'b1);
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         if (k == 1) begin valid_a = 1'b0; valid_b = 1'b0; end
         e = model(k, RA, PA, SA, q, last_a);
         n_vec++;
         if (obs_a !== e) begin n_err++; $display("FAIL abort_pre_a k=%0d got %h want %h", k, obs_a, e); end
      end
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if (obs_a !== RST_OUTS) begin n_err++; $display("FAIL abort_now_a got %h want %h", obs_a, RST_OUTS); end
      n_vec++;
      if (obs_b !== RST_OUTS) begin n_err++; $display("FAIL abort_now_b got %h want %h", obs_b, RST_OUTS); end
      for (int j = 0; j < 9; j++) begin
         @(negedge clk);
         if (j == 3) rst_n = 1'b1;
         n_vec++;
         if (obs_a !== RST_OUTS) begin n_err++; $display("FAIL abort_hold_a j=%0d got %h want %h", j, obs_a, RST_OUTS); end
         n_vec++;
         if (obs_b !== RST_OUTS) begin n_err++; $display("FAIL abort_hold_b j=%0d got %h want %h", j, obs_b, RST_OUTS); end
      end
      last_a = RST_OUTS;
      last_b = RST_OUTS;
   endtask

   initial begin
      test_reset();
      test_sequences();
      test_back_to_back();
      test_sample_once();
      test_abort();
      test_sequences();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mux_switch_sequencer.md
MUX_SWITCH_SEQUENCER -- requirements
Module: mux_switch_sequencer

Interface
REQ-001 Parameter RST_CYCLES, default 4, cycles all design resets are held before the select changes (range 1..255).
REQ-002 Parameter CONF_PULSES, default 3, rising edges issued on o_mux_conf_clk per switch (range 2..15).
REQ-003 Parameter SETTLE_CYCLES, default 8, cycles waited after the last conf-clock edge before release (range 1..255).
REQ-004 Ports (name direction width meaning) SHALL be as follows:
- wb_clk_i  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_req_valid  in  1  switch request.
- o_req_ready  out  1  request accepted when valid&&ready.
- i_req_sel  in  4  target design ID.
- i_req_sys_reset_en  in  1  target value for sys-reset gating, active-high.
- i_req_auto_reset_en  in  1  target value for auto-reset gating, active-high.
- o_mux_conf_clk  out  1  registered configuration clock for the mux control DFFs.
- o_mux_sel  out  4  design select.
- o_mux_sys_reset_enb  out  1  active-low sys-reset enable.
- o_mux_auto_reset_enb  out  1  active-low auto-reset enable.
- o_design_reset  out  8  per-design reset, active-high, IDs 0..7.
- o_busy  out  1  sequence in progress.
- o_done  out  1  one-cycle pulse at sequence completion.
- o_cur_sel  out  4  last committed select.

Function
REQ-005 The FSM SHALL have states IDLE, ASSERT, PULSE, SETTLE, DONE; no other states reachable.
REQ-006 o_req_ready SHALL equal (state==IDLE); o_busy SHALL equal its inverse.
REQ-007 On accept at edge T: latch sel/sys/auto request fields; ASSERT occupies cycles T+1..T+RST_CYCLES.
REQ-008 In ASSERT, o_design_reset SHALL be 8'hFF from the first ASSERT cycle.
REQ-009 On entry to PULSE, o_mux_sel, o_mux_sys_reset_enb (= !sys_en), o_mux_auto_reset_enb (= !auto_en) SHALL update while o_mux_conf_clk is 0.
REQ-010 PULSE SHALL last 2*CONF_PULSES cycles; o_mux_conf_clk is 0,1,0,1,... (low first), ending low at exit.
REQ-011 o_mux_sel and enb outputs SHALL be stable from PULSE entry until the next PULSE entry.
REQ-012 SETTLE SHALL last SETTLE_CYCLES cycles; all outputs held.
REQ-013 DONE SHALL last 1 cycle: o_done=1, o_cur_sel=latched sel, o_design_reset bit[sel] cleared if sel<8, other bits remain 1; sel>=8 leaves 8'hFF.
REQ-014 After DONE, state SHALL return to IDLE; o_design_reset holds its value until next accept.
REQ-015 Total latency with defaults: accept at T, o_done at T+19, o_req_ready high at T+20.
REQ-016 i_req_valid while busy SHALL be ignored (no queuing); the requester must hold valid until ready.
REQ-017 A request with sel equal to o_cur_sel SHALL run the full sequence (acts as design re-reset).
REQ-018 Counters SHALL be 8-bit, reload on each state entry, never wrap within a state.
REQ-019 i_req_* SHALL be sampled only at the accept edge; later changes have no effect on the running sequence.

Reset
REQ-020 rst_n low SHALL immediately force: state IDLE, o_mux_conf_clk 0, o_mux_sel 4'hF, o_cur_sel 4'hF, o_mux_sys_reset_enb 1, o_mux_auto_reset_enb 0, o_design_reset 8'hFF, o_done 0.
REQ-021 rst_n asserted mid-sequence SHALL abort it with the REQ-020 values; no further conf-clock edges until a new accept.
REQ-022 After rst_n deasserts, o_req_ready SHALL be 1 on the first clock.

Verification
REQ-023 Reset, then req sel=2 sys=1 auto=1 -> design_reset FF at T+1..T+18; sel=2 from T+5; 3 conf edges at T+6/8/10; done at T+19; design_reset 8'hFB.
REQ-024 Req sel=12 -> full sequence; o_done at T+19; o_design_reset stays 8'hFF; o_cur_sel=12.
REQ-025 Second valid asserted at T+3 with sel=0 -> ignored until T+20, then accepted; final design_reset 8'hFE.
REQ-026 rst_n low at T+7 during PULSE -> conf_clk 0, mux_sel F, design_reset FF instantly; no done pulse.
REQ-027 Change i_req_sel at T+2 -> o_mux_sel still equals value sampled at T.
REQ-028 Parameters RST_CYCLES=1 CONF_PULSES=2 SETTLE_CYCLES=1 -> done at T+7, exactly 2 conf rising edges.
